column_drop_unit: RTL

Parametrised, clocked successor to the team's column-position calculator for the Connect4 board. It owns the per-column fill counters internally and accepts one drop request at a time from the debounced column buttons. For each request it returns the linear cell index of the landing slot, or a rejection status, and it advances the matching counter. It sits between the button/debounce logic and the board-state RAM/display writer.

---
 rtl/column_drop_unit.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/column_drop_unit.sv
// Connect4 column drop unit: owns per-column fill counters and turns one-hot
// column requests into landing cell indices. Optional undo via COLDROP_UNDO_EN.
module column_drop_unit #(
  parameter  int unsigned COLS = 4,
  parameter  int unsigned ROWS = 4,
  localparam int unsigned CW   = $clog2(ROWS + 1),
  localparam int unsigned PW   = $clog2(COLS * ROWS + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               req_valid,
  input  logic [COLS-1:0]    req_col_n,
  output logic               req_ready,
  input  logic               undo,
  output logic               resp_valid,
  output logic [PW-1:0]      resp_pos,
  output logic [1:0]         resp_status,
  output logic [COLS*CW-1:0] heights,
  output logic               board_full
);

  localparam int unsigned IW = (COLS > 1) ? $clog2(COLS) : 1;

  localparam logic [1:0] ST_PLACED = 2'b00;
  localparam logic [1:0] ST_FULL   = 2'b01;
  localparam logic [1:0] ST_BADSEL = 2'b10;
  localparam logic [1:0] ST_UNDONE = 2'b11;

  typedef enum logic [1:0] {IDLE, EVAL, HOLD} state_e;
  typedef enum logic [1:0] {ACT_NONE, ACT_INC, ACT_DEC} act_e;

  state_e          state_q, state_d;
  act_e            act_q, act_d;
  logic [IW-1:0]   act_col_q, act_col_d;
  logic [CW-1:0]   heights_q [COLS];
  logic [CW-1:0]   heights_d [COLS];
  logic            resp_valid_q, resp_valid_d;
  logic [PW-1:0]   resp_pos_q, resp_pos_d;
  logic [1:0]      resp_status_q, resp_status_d;

`ifdef COLDROP_UNDO_EN
  logic            hist_valid_q, hist_valid_d;
  logic [IW-1:0]   hist_col_q, hist_col_d;
  logic [CW-1:0]   hist_h_c;
  logic [PW-1:0]   undo_pos_c;
`else
  logic            unused_undo_c;
  assign unused_undo_c = undo;
`endif

  // Request decode: exactly one low bit selects a column
  logic [COLS-1:0] sel_c;
  logic            onehot_c;
  logic [IW-1:0]   idx_c;
  logic [CW-1:0]   hsel_c;
  logic            col_full_c;
  logic [PW-1:0]   place_pos_c;

  assign sel_c    = ~req_col_n;
  assign onehot_c = (sel_c != '0) && ((sel_c & (sel_c - COLS'(1))) == '0);

  always_comb begin
    idx_c = '0;
    for (int i = 0; i < COLS; i++) begin
      if (sel_c[i]) idx_c = IW'(i);
    end
  end

  assign hsel_c      = heights_q[idx_c];
  assign col_full_c  = (hsel_c == CW'(ROWS));
  assign place_pos_c = PW'(hsel_c) * PW'(COLS) + PW'(idx_c);

`ifdef COLDROP_UNDO_EN
  // Removed cell sits one below the current top of the recorded column
  assign hist_h_c   = heights_q[hist_col_q] - CW'(1);
  assign undo_pos_c = PW'(hist_h_c) * PW'(COLS) + PW'(hist_col_q);
`endif

  // Next-state, response and counter update
  always_comb begin
    state_d       = state_q;
    act_d         = act_q;
    act_col_d     = act_col_q;
    heights_d     = heights_q;
    resp_valid_d  = 1'b0;
    resp_pos_d    = resp_pos_q;
    resp_status_d = resp_status_q;
`ifdef COLDROP_UNDO_EN
    hist_valid_d  = hist_valid_q;
    hist_col_d    = hist_col_q;
`endif

    if (clear) begin
      for (int i = 0; i < COLS; i++) heights_d[i] = '0;
      act_d   = ACT_NONE;
      state_d = IDLE;
`ifdef COLDROP_UNDO_EN
      hist_valid_d = 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_valid) begin
            resp_valid_d = 1'b1;
            state_d      = EVAL;
            act_col_d    = idx_c;
            if (!onehot_c) begin
              resp_status_d = ST_BADSEL;
              resp_pos_d    = '1;
              act_d         = ACT_NONE;
            end else if (col_full_c) begin
              resp_status_d = ST_FULL;
              resp_pos_d    = '1;
              act_d         = ACT_NONE;
            end else begin
              resp_status_d = ST_PLACED;
              resp_pos_d    = place_pos_c;
              act_d         = ACT_INC;
            end
`ifdef COLDROP_UNDO_EN
          end else if (undo && hist_valid_q) begin
            resp_valid_d  = 1'b1;
            resp_status_d = ST_UNDONE;
            resp_pos_d    = undo_pos_c;
            act_d         = ACT_DEC;
            act_col_d     = hist_col_q;
            hist_valid_d  = 1'b0;
            state_d       = EVAL;
`endif
          end
        end
        EVAL: begin
          if (act_q == ACT_INC) begin
            heights_d[act_col_q] = heights_q[act_col_q] + CW'(1);
`ifdef COLDROP_UNDO_EN
            hist_valid_d = 1'b1;
            hist_col_d   = act_col_q;
`endif
          end else if (act_q == ACT_DEC) begin
            heights_d[act_col_q] = heights_q[act_col_q] - CW'(1);
          end
          act_d   = ACT_NONE;
          state_d = HOLD;
        end
        HOLD: begin
          if (!req_valid) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      act_q         <= ACT_NONE;
      act_col_q     <= '0;
      for (int i = 0; i < COLS; i++) heights_q[i] <= '0;
      resp_valid_q  <= 1'b0;
      resp_pos_q    <= '1;
      resp_status_q <= ST_PLACED;
`ifdef COLDROP_UNDO_EN
      hist_valid_q  <= 1'b0;
      hist_col_q    <= '0;
`endif
    end else begin
      state_q       <= state_d;
      act_q         <= act_d;
      act_col_q     <= act_col_d;
      heights_q     <= heights_d;
      resp_valid_q  <= resp_valid_d;
      resp_pos_q    <= resp_pos_d;
      resp_status_q <= resp_status_d;
`ifdef COLDROP_UNDO_EN
      hist_valid_q  <= hist_valid_d;
      hist_col_q    <= hist_col_d;
`endif
    end
  end

  assign req_ready   = (state_q == IDLE);
  assign resp_valid  = resp_valid_q;
  assign resp_pos    = resp_pos_q;
  assign resp_status = resp_status_q;

  always_comb begin
    heights    = '0;
    board_full = 1'b1;
    for (int i = 0; i < COLS; i++) begin
      heights[i*CW +: CW] = heights_q[i];
      if (heights_q[i] != CW'(ROWS)) board_full = 1'b0;
    end
  end

endmodule
